// File: rtl/alu_cmd_sequencer_if.sv
// Command-load, replay-control and ALU-side signals of the ALU command sequencer.
// The slave modport is the sequencer; the master modport is the host plus the ALU.
interface alu_cmd_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             load_valid;
  logic [1:0]       load_op;
  logic [WIDTH-1:0] load_operand;
  logic             load_ready;
  logic             clear;
  logic             start;
  logic             busy;
  logic             done;
  logic [CW-1:0]    count;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_operand;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic [3:0]       err_count;

  modport slave (
    input  load_valid, load_op, load_operand, clear, start, alu_result,
    output load_ready, busy, done, count, alu_op, alu_operand, expected, mismatch, err_count
  );

  modport master (
    output load_valid, load_op, load_operand, clear, start, alu_result,
    input  load_ready, busy, done, count, alu_op, alu_operand, expected, mismatch, err_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers a short ALU program, replays it one command per clock and checks each
// ALU result against a shadow accumulator; done pulses after the last check.
module alu_cmd_sequencer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input logic                clock,
  input logic                reset_L,
  alu_cmd_sequencer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
  } cmd_t;

  state_t           state, state_nxt;
  cmd_t             entry [DEPTH];
  logic [CW-1:0]    count;
  logic [IW-1:0]    idx;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_operand;
  logic [WIDTH-1:0] expected;
  logic             check_en;
  logic             mismatch;
  logic [3:0]       err_count;
  logic             not_full;
  logic             last_issue;
  logic             run_go;
  logic             empty_go;
  logic             load_fire;

  function automatic logic [WIDTH-1:0] alu_apply(input logic [WIDTH-1:0] a,
                                                 input logic [1:0]       op,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  assign not_full   = (count < CW'(DEPTH));
  assign last_issue = (CW'(idx) == count - CW'(1));
  // clear outranks start, start outranks load
  assign run_go     = (state == S_IDLE) && !bus.clear && bus.start && (count != '0);
  assign empty_go   = (state == S_IDLE) && !bus.clear && bus.start && (count == '0);
  assign load_fire  = (state == S_IDLE) && !bus.clear && !bus.start && bus.load_valid && not_full;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (run_go)        state_nxt = S_RUN;
        else if (empty_go) state_nxt = S_DONE;
      end
      S_RUN:   if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready = (state == S_IDLE) && not_full;
    bus.busy       = (state == S_RUN) || (state == S_DRAIN);
    bus.done       = (state == S_DONE);
  end

  // queue storage needs no reset: only entries below count are ever read
  always_ff @(posedge clock) begin
    if (load_fire) entry[IW'(count)] <= {bus.load_op, bus.load_operand};
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      count       <= '0;
      idx         <= '0;
      alu_op      <= 2'b00;
      alu_operand <= '0;
      expected    <= '0;
      check_en    <= 1'b0;
      mismatch    <= 1'b0;
      err_count   <= 4'd0;
    end else begin
      // the ALU applies whatever sits on its bus at this edge; mirror it here
      check_en <= (state == S_RUN);
      if (state == S_RUN) expected <= alu_apply(expected, alu_op, alu_operand);

      // result of the previous edge's command is visible now
      if (check_en && (bus.alu_result != expected)) begin
        mismatch <= 1'b1;
        if (err_count != 4'hF) err_count <= err_count + 4'd1;
      end

      alu_op      <= 2'b00;
      alu_operand <= '0;

      if ((state == S_IDLE) && bus.clear) count <= '0;
      if (load_fire) count <= count + CW'(1);

      if (run_go) begin
        idx         <= '0;
        alu_op      <= entry[0].op;
        alu_operand <= entry[0].operand;
        mismatch    <= 1'b0;
        err_count   <= 4'd0;
      end

      if ((state == S_RUN) && !last_issue) begin
        idx         <= idx + IW'(1);
        alu_op      <= entry[idx + IW'(1)].op;
        alu_operand <= entry[idx + IW'(1)].operand;
      end
    end
  end

  assign bus.count       = count;
  assign bus.alu_op      = alu_op;
  assign bus.alu_operand = alu_operand;
  assign bus.expected    = expected;
  assign bus.mismatch    = mismatch;
  assign bus.err_count   = err_count;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a small accumulator ALU closes the loop and a
// queue-based model predicts bus traffic, shadow values and error counts.
module tb_alu_cmd_sequencer;
  localparam int DEPTH = 8;
  localparam int WIDTH = 4;

  typedef struct {
    logic [1:0] op;
    logic [3:0] val;
  } mcmd_t;

  logic clock = 1'b0;
  logic reset_L = 1'b0;
  always #5 clock = ~clock;

  alu_cmd_sequencer_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  alu_cmd_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock   (clock),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // accumulator ALU sharing reset_L; force_bad corrupts its visible result
  logic [3:0] alu_acc;
  logic       force_bad = 1'b0;
  always @(posedge clock or negedge reset_L) begin
    if (!reset_L) alu_acc <= 4'd0;
    else case (bus.alu_op)
      2'b00:   alu_acc <= alu_acc + bus.alu_operand;
      2'b01:   alu_acc <= alu_acc - bus.alu_operand;
      2'b10:   alu_acc <= alu_acc | bus.alu_operand;
      default: alu_acc <= alu_acc ^ bus.alu_operand;
    endcase
  end
  assign bus.alu_result = force_bad ? ~alu_acc : alu_acc;

  int    total  = 0;
  int    passed = 0;
  mcmd_t q[$];
  int    mexp = 0;

  function automatic int model_step(input int acc, input mcmd_t c);
    case (c.op)
      2'd0:    return (acc + c.val) % 16;
      2'd1:    return (acc - c.val + 16) % 16;
      2'd2:    return acc | c.val;
      default: return acc ^ c.val;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [1:0] op, input logic [3:0] val);
    mcmd_t c;
    bit    rdy;
    rdy = (q.size() < DEPTH);
    bus.load_valid = 1'b1; bus.load_op = op; bus.load_operand = val;
    total++; if (bus.load_ready !== rdy) $display("FAIL load_ready act=%0b exp=%0b", bus.load_ready, rdy); else passed++;
    tick();
    bus.load_valid = 1'b0;
    if (rdy) begin c.op = op; c.val = val; q.push_back(c); end
    total++; if (bus.count !== q.size()) $display("FAIL load_count act=%0d exp=%0d", bus.count, q.size()); else passed++;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    q.delete();
    total++; if (bus.count !== 0) $display("FAIL clear_count act=%0d exp=0", bus.count); else passed++;
  endtask

  // replays the modelled queue; bad_idx >= 0 corrupts the check of that command
  task automatic run_prog(input int bad_idx);
    int n;
    int exp_err;
    n = q.size();
    exp_err = (bad_idx >= 0) ? 1 : 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      total++; if (bus.alu_op !== q[k].op || bus.alu_operand !== q[k].val)
        $display("FAIL issue[%0d] act=%0d/%0h exp=%0d/%0h", k, bus.alu_op, bus.alu_operand, q[k].op, q[k].val); else passed++;
      total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.load_ready !== 1'b0)
        $display("FAIL run_flags[%0d] busy=%0b done=%0b rdy=%0b exp 1/0/0", k, bus.busy, bus.done, bus.load_ready); else passed++;
      mexp = model_step(mexp, q[k]);
      tick();
      force_bad = (k == bad_idx);
      total++; if (bus.expected !== mexp) $display("FAIL shadow[%0d] act=%0h exp=%0h", k, bus.expected, mexp); else passed++;
    end
    total++; if (bus.alu_op !== 2'b00 || bus.alu_operand !== 4'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL drain op=%0d opnd=%0h busy=%0b done=%0b exp 0/0/1/0", bus.alu_op, bus.alu_operand, bus.busy, bus.done); else passed++;
    tick();
    force_bad = 1'b0;
    total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) $display("FAIL done_pulse done=%0b busy=%0b exp 1/0", bus.done, bus.busy); else passed++;
    total++; if (bus.err_count !== exp_err || bus.mismatch !== (exp_err != 0))
      $display("FAIL final_err cnt=%0d mm=%0b exp=%0d/%0b", bus.err_count, bus.mismatch, exp_err, exp_err != 0); else passed++;
    total++; if (bus.expected !== mexp) $display("FAIL final_shadow act=%0h exp=%0h", bus.expected, mexp); else passed++;
    tick();
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.count !== n)
      $display("FAIL post_run done=%0b busy=%0b count=%0d exp 0/0/%0d", bus.done, bus.busy, bus.count, n); else passed++;
  endtask

  task automatic check_reset_values(input string tag);
    total++; if (bus.count !== 0 || bus.load_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL %s_ctl count=%0d rdy=%0b busy=%0b done=%0b exp 0/1/0/0", tag, bus.count, bus.load_ready, bus.busy, bus.done); else passed++;
    total++; if (bus.alu_op !== 2'b00 || bus.alu_operand !== 4'd0 || bus.expected !== 4'd0 || bus.mismatch !== 1'b0 || bus.err_count !== 4'd0)
      $display("FAIL %s_dat op=%0d opnd=%0h exp=%0h mm=%0b err=%0d all 0 required", tag, bus.alu_op, bus.alu_operand, bus.expected, bus.mismatch, bus.err_count); else passed++;
  endtask

  task automatic test_reset();
    #1;
    check_reset_values("reset");
    tick();
    reset_L = 1'b1;
    tick();
    check_reset_values("after_reset");
  endtask

  task automatic test_directed();
    do_clear();
    do_load(2'd0, 4'h3);
    do_load(2'd0, 4'h5);
    do_load(2'd1, 4'h2);
    do_load(2'd3, 4'hF);
    run_prog(-1);
    total++; if (bus.expected !== 4'h9) $display("FAIL directed_first act=%0h exp=9", bus.expected); else passed++;
    run_prog(-1);
    total++; if (bus.expected !== 4'h0) $display("FAIL directed_replay act=%0h exp=0", bus.expected); else passed++;
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < DEPTH + 1; i++) do_load(2'($urandom_range(3)), 4'($urandom_range(15)));
    total++; if (bus.load_ready !== 1'b0 || bus.count !== DEPTH)
      $display("FAIL full rdy=%0b count=%0d exp 0/%0d", bus.load_ready, bus.count, DEPTH); else passed++;
    run_prog(-1);
  endtask

  task automatic test_mismatch();
    run_prog($urandom_range(q.size() - 1));
    run_prog(-1);
  endtask

  task automatic test_empty_start();
    int keep;
    keep = mexp;
    do_clear();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.alu_op !== 2'b00 || bus.alu_operand !== 4'd0)
      $display("FAIL empty_done done=%0b busy=%0b op=%0d opnd=%0h exp 1/0/0/0", bus.done, bus.busy, bus.alu_op, bus.alu_operand); else passed++;
    tick();
    total++; if (bus.done !== 1'b0 || bus.expected !== keep)
      $display("FAIL empty_after done=%0b exp_val=%0h req 0/%0h", bus.done, bus.expected, keep); else passed++;
  endtask

  task automatic test_priority();
    do_load(2'd0, 4'h1);
    do_load(2'd2, 4'h4);
    bus.clear = 1'b1; bus.start = 1'b1; bus.load_valid = 1'b1;
    tick();
    bus.clear = 1'b0; bus.start = 1'b0; bus.load_valid = 1'b0;
    q.delete();
    total++; if (bus.count !== 0 || bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL priority count=%0d busy=%0b done=%0b exp 0/0/0", bus.count, bus.busy, bus.done); else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      do_clear();
      for (int i = 0; i < int'($urandom_range(DEPTH, 1)); i++)
        do_load(2'($urandom_range(3)), 4'($urandom_range(15)));
      run_prog(($urandom_range(2) == 0) ? int'($urandom_range(q.size() - 1)) : -1);
      if ($urandom_range(1) == 1) run_prog(-1);
    end
  endtask

  task automatic test_reset_midrun();
    do_clear();
    for (int i = 0; i < 5; i++) do_load(2'($urandom_range(3)), 4'($urandom_range(15)));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset_L = 1'b0;
    #1;
    check_reset_values("midrun");
    tick();
    reset_L = 1'b1;
    q.delete();
    mexp = 0;
    tick();
    check_reset_values("midrun_release");
    do_load(2'd0, 4'h7);
    run_prog(-1);
  endtask

  initial begin
    bus.load_valid = 1'b0; bus.load_op = 2'b00; bus.load_operand = 4'd0;
    bus.clear = 1'b0; bus.start = 1'b0;
    test_reset();
    test_directed();
    test_full();
    test_mismatch();
    test_empty_start();
    test_priority();
    test_random();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
